// File: rtl/unit_in_sender.sv
// ---------------------------------------------------------------------------
// unit_in_sender
//
// Transmit side of the unit-input interface. Pops packets from the upstream
// input FIFO and streams each whole packet to one computing unit chosen
// round-robin among the units that are ready and not almost full. Packets
// longer than MAX_PKT_WORDS are cut short: the last sent word carries ctrl=1
// and the remainder is popped and dropped.
//
// Ports:
//   CLK, rst        clock (rising edge), asynchronous active-high reset
//   in_data/in_last upstream FIFO word and end-of-packet flag
//   in_empty        upstream FIFO empty
//   in_rd_en        upstream pop (combinational)
//   unit_in         shared data bus to all units (registered)
//   unit_in_ctrl    end-of-packet marker for the current word (registered)
//   unit_in_wr_en   one-hot per-unit write enable (registered)
//   unit_in_afull   per-unit almost full (>= 2 more writes accepted)
//   unit_in_ready   per-unit "can accept a new packet"
//   busy            sender is not idle
//   pkt_count       packets completed, wrapping 16-bit counter
//   err_pkt_len     sticky flag: a packet was force-terminated
// ---------------------------------------------------------------------------
module unit_in_sender #(
   parameter int N_UNITS          = 4,
   parameter int UNIT_INPUT_WIDTH = 8,
   parameter int MAX_PKT_WORDS    = 64
) (
   input  logic                        CLK,
   input  logic                        rst,
   input  logic [UNIT_INPUT_WIDTH-1:0] in_data,
   input  logic                        in_last,
   input  logic                        in_empty,
   output logic                        in_rd_en,
   output logic [UNIT_INPUT_WIDTH-1:0] unit_in,
   output logic                        unit_in_ctrl,
   output logic [N_UNITS-1:0]          unit_in_wr_en,
   input  logic [N_UNITS-1:0]          unit_in_afull,
   input  logic [N_UNITS-1:0]          unit_in_ready,
   output logic                        busy,
   output logic [15:0]                 pkt_count,
   output logic                        err_pkt_len
);

   localparam int PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
   localparam int CNT_W = $clog2(MAX_PKT_WORDS) + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PKT_WORDS - 1);
   localparam logic [PTR_W-1:0] TOP_UNIT = PTR_W'(N_UNITS - 1);

   typedef enum logic [1:0] {IDLE, SELECT, SEND, DISCARD} state_t;

   state_t             state;
   state_t             state_next;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   sel;
   logic [PTR_W-1:0]   sel_inc;
   logic [PTR_W-1:0]   pick;
   logic [PTR_W-1:0]   cand;
   logic               pick_valid;
   logic [CNT_W-1:0]   word_cnt;
   logic               at_max;
   logic               send_pop;
   logic [N_UNITS-1:0] eligible;
   logic [N_UNITS-1:0] sel_onehot;

   assign eligible = unit_in_ready & ~unit_in_afull;
   assign at_max   = (word_cnt == LAST_IDX);
   assign sel_inc  = (sel == TOP_UNIT) ? '0 : sel + 1'b1;
   assign busy     = (state != IDLE);
   assign send_pop = (state == SEND) && in_rd_en;

   for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_onehot
      assign sel_onehot[gi] = (sel == PTR_W'(gi));
   end

   // Round-robin pick: walk the candidates from the farthest offset back to
   // rr_ptr itself so the nearest eligible unit (lowest offset) wins.
   always_comb begin
      pick       = rr_ptr;
      pick_valid = 1'b0;
      cand       = rr_ptr;
      for (int k = N_UNITS - 1; k >= 0; k--) begin
         cand = PTR_W'((int'(rr_ptr) + k) % N_UNITS);
         if (eligible[cand]) begin
            pick       = cand;
            pick_valid = 1'b1;
         end
      end
   end

   // Next-state and FIFO pop.
   always_comb begin
      state_next = state;
      in_rd_en   = 1'b0;
      case (state)
         IDLE: begin
            if (!in_empty) state_next = SELECT;
         end
         SELECT: begin
            if (pick_valid) state_next = SEND;
         end
         SEND: begin
            in_rd_en = ~in_empty & ~unit_in_afull[sel];
            if (in_rd_en) begin
               if (in_last)     state_next = IDLE;
               else if (at_max) state_next = DISCARD;
            end
         end
         DISCARD: begin
            in_rd_en = ~in_empty;
            if (in_rd_en && in_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Datapath: output word register is loaded only on a pop, so the bus
   // shows the popped word exactly one cycle after the FIFO read.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         rr_ptr        <= '0;
         sel           <= '0;
         word_cnt      <= '0;
         unit_in       <= '0;
         unit_in_ctrl  <= 1'b0;
         unit_in_wr_en <= '0;
         pkt_count     <= '0;
         err_pkt_len   <= 1'b0;
      end else begin
         unit_in_wr_en <= '0;
         unit_in_ctrl  <= 1'b0;
         if (state == SELECT && pick_valid) begin
            sel      <= pick;
            word_cnt <= '0;
         end
         if (send_pop) begin
            unit_in       <= in_data;
            unit_in_wr_en <= sel_onehot;
            unit_in_ctrl  <= in_last | at_max;
            word_cnt      <= word_cnt + 1'b1;
            // Either a normal end or a forced cut completes the packet.
            if (in_last | at_max) begin
               pkt_count <= pkt_count + 16'd1;
               rr_ptr    <= sel_inc;
            end
            if (!in_last && at_max) err_pkt_len <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_unit_in_sender.sv
// ---------------------------------------------------------------------------
// tb_unit_in_sender
//
// Self-checking bench for unit_in_sender. A queue models the upstream FIFO;
// a scoreboard of expected unit writes is built per packet from the
// round-robin and length-limit rules; a monitor compares every bus write.
// ---------------------------------------------------------------------------
module tb_unit_in_sender;

   localparam int MAXW = 64;

   logic       CLK;
   logic       rst;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_empty;
   logic       in_rd_en;
   logic [7:0] unit_in;
   logic       unit_in_ctrl;
   logic [3:0] unit_in_wr_en;
   logic [3:0] unit_in_afull;
   logic [3:0] unit_in_ready;
   logic       busy;
   logic [15:0] pkt_count;
   logic       err_pkt_len;

   unit_in_sender #(
      .N_UNITS(4),
      .UNIT_INPUT_WIDTH(8),
      .MAX_PKT_WORDS(MAXW)
   ) dut (
      .CLK(CLK),
      .rst(rst),
      .in_data(in_data),
      .in_last(in_last),
      .in_empty(in_empty),
      .in_rd_en(in_rd_en),
      .unit_in(unit_in),
      .unit_in_ctrl(unit_in_ctrl),
      .unit_in_wr_en(unit_in_wr_en),
      .unit_in_afull(unit_in_afull),
      .unit_in_ready(unit_in_ready),
      .busy(busy),
      .pkt_count(pkt_count),
      .err_pkt_len(err_pkt_len)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic [7:0] data;
      logic       last;
      bit         wr;     // this word is expected to reach a unit
   } fifo_t;

   typedef struct {
      int         unit;
      logic [7:0] data;
      logic       ctrl;
   } exp_t;

   fifo_t      fifo_q[$];
   exp_t       exp_q[$];
   logic [7:0] pkt_words[$];

   int         n_tests = 0;
   int         n_fail  = 0;
   int         total_writes = 0;
   int         pkt_wr = 0;
   int         rr_model = 0;
   int         pkt_model = 0;
   logic       err_model = 1'b0;
   logic [3:0] ready_mask = 4'hF;
   logic [3:0] afull_dir = 4'h0;
   bit         rand_mode = 1'b0;
   bit         in_pkt = 1'b0;
   bit         pend_write = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   function automatic int pick_unit(input logic [3:0] elig, input int rr);
      int u;
      for (int k = 0; k < 4; k++) begin
         u = (rr + k) % 4;
         if (elig[u[1:0]]) return u;
      end
      return -1;
   endfunction

   // Expected unit writes for the packet in pkt_words, destined by the
   // current ready mask and round-robin pointer.
   task automatic add_expected();
      int   dest;
      int   len;
      int   n;
      exp_t e;
      len  = pkt_words.size();
      dest = pick_unit(ready_mask & ~afull_dir, rr_model);
      n    = (len > MAXW) ? MAXW : len;
      for (int i = 0; i < n; i++) begin
         e.unit = dest;
         e.data = pkt_words[i];
         e.ctrl = (i == n - 1);
         exp_q.push_back(e);
      end
      pkt_model++;
      if (len > MAXW) err_model = 1'b1;
      rr_model = (dest + 1) % 4;
   endtask

   task automatic gen_pkt(input int len, input logic [7:0] base, input bit rnd, input bit do_exp);
      fifo_t      f;
      logic [7:0] d;
      pkt_words.delete();
      for (int i = 0; i < len; i++) begin
         d = rnd ? 8'($urandom) : 8'(base + 8'(i));
         f.data = d;
         f.last = (i == len - 1);
         f.wr   = (i < MAXW);
         fifo_q.push_back(f);
         pkt_words.push_back(d);
      end
      if (do_exp) add_expected();
   endtask

   task automatic wait_idle(input string tag);
      int i;
      for (i = 0; i < 3000; i++) begin
         @(posedge CLK); #2;
         if (fifo_q.size() == 0 && exp_q.size() == 0 && !busy) break;
      end
      if (i == 3000) chk({tag, "_timeout"}, 32'd1, 32'd0);
      chk({tag, "_pkt_count"}, 32'(pkt_count), 32'(pkt_model % 65536));
      chk({tag, "_err"}, 32'(err_pkt_len), 32'(err_model));
   endtask

   task automatic wait_writes(input int target, input string tag);
      int i;
      for (i = 0; i < 500; i++) begin
         if (total_writes >= target) break;
         @(posedge CLK); #2;
      end
      if (i == 500) chk({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   // Cycle monitor: checks the bus at the falling edge, then drives the
   // upstream FIFO / unit status and performs model pops.
   initial begin
      exp_t       e;
      fifo_t      f;
      logic       wr_any;
      logic [3:0] af;
      in_empty      = 1'b1;
      in_data       = '0;
      in_last       = 1'b0;
      unit_in_afull = '0;
      unit_in_ready = 4'hF;
      forever begin
         @(negedge CLK);
         if (rst) begin
            pend_write = 1'b0;
            in_pkt     = 1'b0;
         end else begin
            wr_any = |unit_in_wr_en;
            chk("wr_vs_pop", 32'(wr_any), 32'(pend_write));
            if (wr_any) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_write", 32'(unit_in_wr_en), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_en", 32'(unit_in_wr_en), 32'(1 << e.unit));
                  chk("data", 32'(unit_in), 32'(e.data));
                  chk("ctrl", 32'(unit_in_ctrl), 32'(e.ctrl));
                  total_writes++;
                  pkt_wr++;
                  in_pkt = !e.ctrl;
                  if (e.ctrl) begin
                     $display("[TB] packet to unit %0d done, %0d writes, pkt_count=%0d",
                              e.unit, pkt_wr, pkt_count);
                     pkt_wr = 0;
                  end
               end
            end else begin
               chk("ctrl_idle", 32'(unit_in_ctrl), 32'd0);
            end
         end
         // Drive inputs for the coming rising edge.
         for (int b = 0; b < 4; b++) af[b] = ($urandom % 4 == 0);
         unit_in_afull = (rand_mode && in_pkt) ? af : afull_dir;
         unit_in_ready = (rand_mode && in_pkt) ? 4'($urandom) : ready_mask;
         if (fifo_q.size() > 0 && !(rand_mode && ($urandom % 4 == 0))) begin
            in_empty = 1'b0;
            in_data  = fifo_q[0].data;
            in_last  = fifo_q[0].last;
         end else begin
            in_empty = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
         end
         #1;
         if (!rst) begin
            if (in_pkt && exp_q.size() > 0 && unit_in_afull[exp_q[0].unit])
               chk("afull_hold", 32'(in_rd_en), 32'd0);
            pend_write = 1'b0;
            if (in_rd_en) begin
               if (in_empty) begin
                  chk("pop_empty", 32'(in_rd_en), 32'd0);
               end else begin
                  f = fifo_q.pop_front();
                  pend_write = f.wr;
               end
            end
         end
      end
   end

   initial begin
      int base;
      int len;
      rst = 1'b1;
      repeat (2) @(posedge CLK);
      #2;
      chk("rst_unit_in", 32'(unit_in), 32'd0);
      chk("rst_ctrl", 32'(unit_in_ctrl), 32'd0);
      chk("rst_wr_en", 32'(unit_in_wr_en), 32'd0);
      chk("rst_rd_en", 32'(in_rd_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pkt_count", 32'(pkt_count), 32'd0);
      chk("rst_err", 32'(err_pkt_len), 32'd0);
      rst = 1'b0;

      // One 5-word packet, all ready: unit 0.
      @(posedge CLK); #2;
      gen_pkt(5, 8'h11, 1'b0, 1'b1);
      wait_idle("t1");

      // Five back-to-back 3-word packets: units 1,2,3,0,1.
      for (int p = 0; p < 5; p++) gen_pkt(3, 8'(8'h20 + 8'(p * 4)), 1'b0, 1'b1);
      wait_idle("t2");

      // Only unit 2 ready.
      ready_mask = 4'b0100;
      gen_pkt(4, 8'h30, 1'b0, 1'b1);
      wait_idle("t3a");

      // Nobody ready: sender must hold in SELECT without popping.
      ready_mask = 4'b0000;
      gen_pkt(3, 8'h38, 1'b0, 1'b0);
      repeat (3) begin @(posedge CLK); #2; end
      for (int c = 0; c < 6; c++) begin
         @(posedge CLK); #2;
         chk("hold_rd_en", 32'(in_rd_en), 32'd0);
         chk("hold_busy", 32'(busy), 32'd1);
      end
      ready_mask = 4'b1000;
      add_expected();
      wait_idle("t3b");

      // afull on the destination for 6 cycles in mid-packet.
      ready_mask = 4'hF;
      base = total_writes;
      gen_pkt(10, 8'h40, 1'b0, 1'b1);
      wait_writes(base + 3, "t4");
      afull_dir = 4'b0001;
      @(posedge CLK); #2;
      base = total_writes;
      repeat (5) begin @(posedge CLK); #2; end
      chk("afull_no_write", 32'(total_writes), 32'(base));
      afull_dir = 4'b0000;
      wait_idle("t4");

      // 70-word packet: cut at 64, rest discarded, then a normal packet.
      gen_pkt(70, 8'h80, 1'b0, 1'b1);
      wait_idle("t5a");
      gen_pkt(2, 8'h50, 1'b0, 1'b1);
      wait_idle("t5b");

      // Reset in mid-packet.
      base = total_writes;
      gen_pkt(8, 8'h60, 1'b0, 1'b1);
      wait_writes(base + 3, "t6");
      rst = 1'b1;
      #1;
      chk("arst_unit_in", 32'(unit_in), 32'd0);
      chk("arst_wr_en", 32'(unit_in_wr_en), 32'd0);
      chk("arst_ctrl", 32'(unit_in_ctrl), 32'd0);
      chk("arst_rd_en", 32'(in_rd_en), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_pkt_count", 32'(pkt_count), 32'd0);
      chk("arst_err", 32'(err_pkt_len), 32'd0);
      fifo_q.delete();
      exp_q.delete();
      in_pkt     = 1'b0;
      pend_write = 1'b0;
      pkt_wr     = 0;
      rr_model   = 0;
      pkt_model  = 0;
      err_model  = 1'b0;
      @(posedge CLK); #2;
      rst = 1'b0;
      gen_pkt(4, 8'h70, 1'b0, 1'b1);
      wait_idle("t6");

      // Randomized traffic: ready masks, stalls, afull, ready drops.
      rand_mode = 1'b1;
      for (int p = 0; p < 30; p++) begin
         ready_mask = 4'($urandom_range(1, 15));
         len = ($urandom % 8 == 0) ? int'($urandom_range(60, 75)) : int'($urandom_range(1, 12));
         gen_pkt(len, 8'h00, 1'b1, 1'b1);
         wait_idle("rnd");
      end
      rand_mode = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
